// File: rtl/sdram_arb_pkg.sv
// Shared widths, slot timing and slot-kind encoding for the SDRAM slot arbiter.
package sdram_arb_pkg;
    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 16;
    localparam int DS_W        = 2;
    localparam int SLOT_CYCLES = 12;

    typedef enum logic [1:0] {
        IDLE_SLOT,
        GRANT_SLOT,
        REFRESH_SLOT
    } slot_kind_e;
endpackage

// File: rtl/sdram_slot_arbiter_if.sv
// Arbiter <-> SDRAM controller bus; master is the arbiter, slave the controller.
interface sdram_slot_arbiter_if;
    import sdram_arb_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DS_W-1:0]   mem_ds;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [63:0]       mem_dout64;

    modport master (
        output mem_req, mem_we, mem_addr, mem_ds, mem_din,
        input  mem_dout, mem_dout64
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_ds, mem_din,
        output mem_dout, mem_dout64
    );
endinterface

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin pick over ports 1..NPORTS-1, starting at i_ptr.
module sdram_rr_pick #(
    parameter int NPORTS = 4,
    parameter int IW     = 2
) (
    input  logic [NPORTS-1:1] i_req,
    input  logic [IW-1:0]     i_ptr,
    output logic              o_vld,
    output logic [IW-1:0]     o_idx
);
    int w_best;
    int w_dist;

    // Cyclic distance from the pointer; the smallest requesting distance wins.
    always_comb begin
        o_vld  = 1'b0;
        o_idx  = IW'(1);
        w_best = NPORTS;
        w_dist = 0;
        for (int i = 1; i < NPORTS; i++) begin
            w_dist = (i - int'(i_ptr) + NPORTS - 1) % (NPORTS - 1);
            if (i_req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_vld  = 1'b1;
                o_idx  = IW'(i);
            end
        end
    end
endmodule

// File: rtl/sdram_slot_arbiter.sv
// Slot-synchronous SDRAM port arbiter: port 0 fixed priority, others round-robin,
// forced refresh slots. Define SDRAM_ARB_DOUT64_EN to add the o_p_dout64 read port.
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS      = 4,
    parameter int REFRESH_MAX = 60
) (
    input  logic                     clk_96,
    input  logic                     init,
    input  logic                     i_clk_8_en,
    input  logic [NPORTS-1:0]        i_p_req,
    input  logic [NPORTS-1:0]        i_p_we,
    input  logic [ADDR_W*NPORTS-1:0] i_p_addr,
    input  logic [DS_W*NPORTS-1:0]   i_p_ds,
    input  logic [DATA_W*NPORTS-1:0] i_p_din,
    output logic [NPORTS-1:0]        o_p_ack,
    output logic [DATA_W-1:0]        o_p_dout,
`ifdef SDRAM_ARB_DOUT64_EN
    output logic [63:0]              o_p_dout64,
`endif
    output logic                     o_refresh_force,
    sdram_slot_arbiter_if.master     mem
);
    localparam int IW = (NPORTS > 2) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(REFRESH_MAX + 1);

    slot_kind_e        r_kind, w_kind_nxt;
    logic              r_clk8_d;
    logic [IW-1:0]     r_gnt_idx;
    logic [IW-1:0]     r_rr_ptr;
    logic [CW-1:0]     r_ref_cnt;
    logic [DATA_W-1:0] r_p_dout;
    logic              r_force;
    logic              r_mem_req, r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DS_W-1:0]   r_mem_ds;
    logic [DATA_W-1:0] r_mem_din;

    logic [NPORTS-1:0][ADDR_W-1:0] w_addr_a;
    logic [NPORTS-1:0][DS_W-1:0]   w_ds_a;
    logic [NPORTS-1:0][DATA_W-1:0] w_din_a;
    logic              w_bnd, w_done, w_rd_ack;
    logic [NPORTS-1:0] w_ack, w_cand;
    logic              w_rr_vld, w_pick_vld;
    logic [IW-1:0]     w_rr_idx, w_pick;

    assign w_addr_a = i_p_addr;
    assign w_ds_a   = i_p_ds;
    assign w_din_a  = i_p_din;

    assign w_bnd    = i_clk_8_en & ~r_clk8_d;
    assign w_done   = w_bnd & ~init & (r_kind == GRANT_SLOT);
    assign w_rd_ack = w_done & ~r_mem_we;

    always_comb begin
        w_ack = '0;
        if (w_done) w_ack[r_gnt_idx] = 1'b1;
    end

    // The port being acked still holds req in this cycle; keep it out of the race.
    assign w_cand = i_p_req & ~w_ack;

    sdram_rr_pick #(.NPORTS(NPORTS), .IW(IW)) u_rr (
        .i_req (w_cand[NPORTS-1:1]),
        .i_ptr (r_rr_ptr),
        .o_vld (w_rr_vld),
        .o_idx (w_rr_idx)
    );

    assign w_pick_vld = w_cand[0] | w_rr_vld;
    assign w_pick     = w_cand[0] ? '0 : w_rr_idx;

    always_comb begin
        w_kind_nxt = r_kind;
        if (w_bnd) begin
            if (r_ref_cnt == CW'(REFRESH_MAX)) w_kind_nxt = REFRESH_SLOT;
            else if (w_pick_vld)                w_kind_nxt = GRANT_SLOT;
            else                                w_kind_nxt = IDLE_SLOT;
        end
    end

    always_ff @(posedge clk_96) begin
        r_clk8_d <= i_clk_8_en;
        if (init) begin
            r_kind     <= IDLE_SLOT;
            r_gnt_idx  <= '0;
            r_rr_ptr   <= IW'(1);
            r_ref_cnt  <= '0;
            r_p_dout   <= '0;
            r_force    <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_ds   <= '0;
            r_mem_din  <= '0;
        end else begin
            r_kind <= w_kind_nxt;
            if (w_rd_ack) r_p_dout <= mem.mem_dout;
            if (w_bnd) begin
                r_force <= (w_kind_nxt == REFRESH_SLOT);
                if (w_kind_nxt == GRANT_SLOT) begin
                    r_gnt_idx  <= w_pick;
                    r_ref_cnt  <= r_ref_cnt + CW'(1);
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= i_p_we[w_pick];
                    r_mem_addr <= w_addr_a[w_pick];
                    r_mem_ds   <= w_ds_a[w_pick];
                    r_mem_din  <= w_din_a[w_pick];
                    if (!w_cand[0])
                        r_rr_ptr <= (w_pick == IW'(NPORTS - 1)) ? IW'(1) : w_pick + IW'(1);
                end else begin
                    // Idle and refresh slots keep addr/ds/din from the last grant.
                    r_ref_cnt <= '0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            end
        end
    end

    assign o_p_ack         = w_ack;
    assign o_p_dout        = w_rd_ack ? mem.mem_dout : r_p_dout;
    assign o_refresh_force = r_force;
    assign mem.mem_req     = r_mem_req;
    assign mem.mem_we      = r_mem_we;
    assign mem.mem_addr    = r_mem_addr;
    assign mem.mem_ds      = r_mem_ds;
    assign mem.mem_din     = r_mem_din;

`ifdef SDRAM_ARB_DOUT64_EN
    logic [63:0] r_p_dout64;

    always_ff @(posedge clk_96) begin
        if (init)          r_p_dout64 <= '0;
        else if (w_rd_ack) r_p_dout64 <= mem.mem_dout64;
    end

    assign o_p_dout64 = w_rd_ack ? mem.mem_dout64 : r_p_dout64;
`else
    logic w_unused_dout64;
    assign w_unused_dout64 = ^mem.mem_dout64;
`endif
endmodule
